// File: rtl/uart_result_tx.sv
// uart_result_tx: serializes a 32-bit FPU result as four UART frames, LSB byte first.
// Define UART_TX_PARITY_EN to add an even-parity bit to each frame (8E1 instead of 8N1).
module uart_result_tx #(
    parameter int CLKS_PER_BIT = 347
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        tx_serial,
    output logic        busy,
    output logic        done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic [31:0]   shreg;
    logic          bit_end;
`ifdef UART_TX_PARITY_EN
    logic          par_acc;
`endif

    assign bit_end  = (baud_cnt == BAUD_LAST);
    assign in_ready = (state == IDLE);
    assign busy     = ~in_ready;

    // Baud counter: runs only while a frame is on the line, wraps on each bit boundary.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            baud_cnt <= '0;
        end else if (state == IDLE || bit_end) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + CW'(1);
        end
    end

    // Frame sequencer: moves the line through start/data/(parity)/stop for each byte.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            tx_serial <= 1'b1;
            done      <= 1'b0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            shreg     <= '0;
`ifdef UART_TX_PARITY_EN
            par_acc   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg     <= in_data;
                        tx_serial <= 1'b0;
                        bit_idx   <= '0;
                        byte_idx  <= '0;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx_serial <= shreg[0];
                        shreg     <= {1'b0, shreg[31:1]};
`ifdef UART_TX_PARITY_EN
                        par_acc   <= shreg[0];
`endif
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            tx_serial <= par_acc;
                            state     <= PARITY;
`else
                            tx_serial <= 1'b1;
                            state     <= STOP;
`endif
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            tx_serial <= shreg[0];
                            shreg     <= {1'b0, shreg[31:1]};
`ifdef UART_TX_PARITY_EN
                            par_acc   <= par_acc ^ shreg[0];
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        tx_serial <= 1'b1;
                        state     <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (byte_idx == 2'd3) begin
                            byte_idx  <= '0;
                            tx_serial <= 1'b1;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            byte_idx  <= byte_idx + 2'd1;
                            tx_serial <= 1'b0;
                            state     <= START;
                        end
                    end
                end
                default: begin
                    tx_serial <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_result_tx.md
UART_RESULT_TX -- requirements
Module: uart_result_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 347, giving wb_clk_i cycles per serial bit (115200 baud at 40 MHz); legal range 2..65535.
REQ-002 SHALL have port wb_clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port wb_rst_i, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port in_data, input, 32, the FPU result word to transmit.
REQ-005 SHALL have port in_valid, input, 1, asserted when in_data is valid.
REQ-006 SHALL have port in_ready, output, 1, asserted when the block can accept a word.
REQ-007 SHALL have port tx_serial, output, 1, the UART line toward mprj_io; it idles high.
REQ-008 SHALL have port busy, output, 1, high while a word is being serialized.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse when a word has been fully sent.

Function
REQ-010 SHALL accept a word on the cycle in which in_valid and in_ready are both high.
- in_data is captured into a 32-bit shift register on that cycle.
REQ-011 SHALL drive in_ready high only in state IDLE; in_valid is ignored in every other state.
REQ-012 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on accept.
- START -> DATA after CLKS_PER_BIT cycles.
- DATA -> STOP, or DATA -> PARITY when parity is compiled in, after 8 bit periods.
- PARITY -> STOP after 1 bit period.
- STOP -> START after 1 bit period when bytes remain, otherwise STOP -> IDLE.
REQ-013 SHALL send the word as 4 frames in little-endian byte order (in_data[7:0] first); within each byte, bit 0 goes first.
REQ-014 SHALL frame each byte as: start bit 0, 8 data bits, optional parity bit, one stop bit 1.
REQ-015 SHALL drive tx_serial low on the first cycle after accept (latency 1).
- Every bit is held for exactly CLKS_PER_BIT cycles.
- There is no idle gap between the 4 frames.
REQ-016 SHALL use a baud counter sized $clog2(CLKS_PER_BIT) that counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- A 3-bit bit index and a 2-bit byte index wrap at 7 and 3 respectively.
REQ-017 SHALL pulse done high for exactly one cycle, on the cycle the FSM returns to IDLE after the stop bit of byte 3.
- in_ready is high on that same cycle, so back-to-back words are possible.
REQ-018 SHALL hold busy high from the cycle after accept through the last stop-bit cycle.
- busy equals the inverse of in_ready.
REQ-019 SHALL keep tx_serial registered and glitch-free (driven directly from a flop).
REQ-020 SHALL NOT change the captured word if in_data changes while busy.

Reset
REQ-021 SHALL, on a wb_clk_i edge with wb_rst_i high, set: state IDLE, tx_serial 1, in_ready 1, busy 0, done 0, all counters 0.
REQ-022 SHALL treat reset mid-frame as an abort: tx_serial is 1 on the next cycle, the partial word is discarded and done does not pulse.
REQ-023 SHALL ignore in_valid while wb_rst_i is high.

Configuration
REQ-024 SHALL, when macro UART_TX_PARITY_EN is defined, insert one even-parity bit (XOR of the 8 data bits) between the data and stop bits.
- Frame is 11 bits; word time is 44*CLKS_PER_BIT cycles.
REQ-025 SHALL, when UART_TX_PARITY_EN is undefined, omit state PARITY entirely.
- Frame is 10 bits; word time is 40*CLKS_PER_BIT cycles.

Verification (CLKS_PER_BIT=4)
REQ-026 Basic word: accept 32'h4208ED91 -> line carries bytes 91, ED, 08, 42 in order, 8N1; done pulses 160 cycles after accept; in_ready is high the same cycle.
REQ-027 Back-to-back: hold in_valid high with 32'h00000022 then 32'hFFFFFFFB -> second accept occurs on the done cycle; no idle gap; bytes 22 00 00 00 FB FF FF FF.
REQ-028 Ignored input: pulse in_valid with 32'h12345678 while busy -> not accepted; the current word completes unchanged; no extra frames.
REQ-029 Reset mid-frame: assert wb_rst_i during byte 2 bit 3 -> tx_serial=1, in_ready=1, busy=0 next cycle; no done pulse; next word transmits correctly.
REQ-030 Parity build with UART_TX_PARITY_EN: send 32'h00002F02 -> parity bits 1, 1, 0, 0 for bytes 02, 2F, 00, 00; done at 176 cycles.
REQ-031 Idle/reset state: after reset with no input for 1000 cycles -> tx_serial constant 1, busy 0, done never pulses.
